led_blink_driver: RTL



---
 rtl/led_blink_driver.sv | 117 +++++++++++
 1 files changed

// File: rtl/led_blink_driver.sv
// Turns per-LED event levels into a blink-then-solid indication.
// One shared prescaler paces every LED's blink phases.
module led_blink_driver #(
  parameter int NUM_LEDS    = 4,
  parameter int TICK_DIV    = 25_000_000,
  parameter int BLINK_COUNT = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_LEDS-1:0] evt,
  input  logic                clr,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                busy
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW = (2 * BLINK_COUNT > 2) ? $clog2(2 * BLINK_COUNT) : 1;
  localparam logic [TW-1:0] TLAST  = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PSTART = PW'(2 * BLINK_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLINK = 2'd1,
    SOLID = 2'd2
  } state_t;

  state_t              st      [NUM_LEDS];
  state_t              st_nx   [NUM_LEDS];
  logic [PW-1:0]       pcnt    [NUM_LEDS];
  logic [PW-1:0]       pcnt_nx [NUM_LEDS];
  logic [NUM_LEDS-1:0] ph;
  logic [NUM_LEDS-1:0] ph_nx;
  logic [NUM_LEDS-1:0] evt_q;
  logic [NUM_LEDS-1:0] rise;
  logic [NUM_LEDS-1:0] led_nx;
  logic                busy_nx;
  logic [TW-1:0]       tcnt;
  logic                tick;

  assign tick = (tcnt == TLAST);
  assign rise = evt & ~evt_q;

  // Next state per LED; an IDLE LED that rises on a tick ignores that tick.
  always_comb begin
    busy_nx = 1'b0;
    led_nx  = '0;
    ph_nx   = ph;
    for (int i = 0; i < NUM_LEDS; i++) begin
      st_nx[i]   = st[i];
      pcnt_nx[i] = pcnt[i];
      case (st[i])
        IDLE: begin
          if (rise[i]) begin
            st_nx[i]   = BLINK;
            ph_nx[i]   = 1'b1;
            pcnt_nx[i] = PSTART;
          end
        end
        BLINK: begin
          if (tick) begin
            if (pcnt[i] == '0) begin
              st_nx[i] = SOLID;
            end else begin
              pcnt_nx[i] = pcnt[i] - 1'b1;
              ph_nx[i]   = ~ph[i];
            end
          end
        end
        SOLID: begin
          st_nx[i] = SOLID;
        end
        default: begin
          st_nx[i] = IDLE;
        end
      endcase
      led_nx[i] = (st_nx[i] == SOLID) | ((st_nx[i] == BLINK) & ph_nx[i]);
      busy_nx   = busy_nx | (st_nx[i] == BLINK);
    end
  end

  // evt_q keeps sampling through clr so a held level cannot retrigger.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt    <= '0;
      evt_q   <= '0;
      ph      <= '0;
      led_out <= '0;
      busy    <= 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        st[i]   <= IDLE;
        pcnt[i] <= '0;
      end
    end else begin
      evt_q <= evt;
      if (clr) begin
        tcnt    <= '0;
        ph      <= '0;
        led_out <= '0;
        busy    <= 1'b0;
        for (int i = 0; i < NUM_LEDS; i++) begin
          st[i]   <= IDLE;
          pcnt[i] <= '0;
        end
      end else begin
        tcnt    <= tick ? '0 : tcnt + 1'b1;
        ph      <= ph_nx;
        led_out <= led_nx;
        busy    <= busy_nx;
        for (int i = 0; i < NUM_LEDS; i++) begin
          st[i]   <= st_nx[i];
          pcnt[i] <= pcnt_nx[i];
        end
      end
    end
  end

endmodule
